// File: rtl/hazard_pkg.sv
// Shared encodings for the multi-cycle hazard controller: forwarding selects
// and divider-timer states.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    // D-stage operand select (feeds the branch comparator)
    localparam logic [1:0] FWD_D_RF = 2'b00;
    localparam logic [1:0] FWD_D_M  = 2'b01;
    localparam logic [1:0] FWD_D_W  = 2'b10;

    // E-stage operand select (feeds the ALU)
    localparam logic [1:0] FWD_E_RF = 2'b00;
    localparam logic [1:0] FWD_E_M  = 2'b10;
    localparam logic [1:0] FWD_E_W  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/hazard_div_timer.sv
// Divider latency timer: holds a div in E until DIV_CYCLES busy cycles have
// elapsed, with start/cancel pulses for the datapath divider.
module hazard_div_timer
    import hazard_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic divE,
    input  logic hold,
    input  logic cancel,
    output logic divstall,
    output logic div_start,
    output logic div_cancel
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start is refused while M is stalled or a flush is in progress; the
    // count itself keeps running through memory stalls.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_start  = 1'b0;
        div_cancel = 1'b0;
        case (state_q)
            IDLE: begin
                if (divE && !hold && !cancel) begin
                    state_d   = BUSY;
                    cnt_d     = CNT_W'(DIV_CYCLES - 1);
                    div_start = 1'b1;
                end
            end
            BUSY: begin
                if (cancel) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    div_cancel = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign divstall = divE && ((state_q == IDLE) || (state_q == BUSY));

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/pipeline controller for the 5-stage core: forwarding, load-use and
// branch stalls, divider latency, memory wait states and exception flushes.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = REG_AW_DEF,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              branchD,
    input  logic              jrD,
    input  logic              jumpD,
    input  logic              balD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic              regwriteE,
    input  logic              memtoregE,
    input  logic              divE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic              regwriteM,
    input  logic              memtoregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteW,
    input  logic              inst_busyF,
    input  logic              data_busyM,
    input  logic              exceptM,
    output logic [1:0]        forwardaD,
    output logic [1:0]        forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              div_start,
    output logic              div_cancel,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushF,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW
);

    function automatic logic reg_hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    logic pend_q, pend_d;
    logic flush_now, lwstall, brstall, divstall, d_stall;
    logic tmr_start, tmr_cancel;
    logic br_hit_rs, br_hit_rt;

    // Load results are not yet available in M, so D never forwards from a load.
    assign forwardaD = (reg_hit(rsD, writeregM) && regwriteM && !memtoregM) ? FWD_D_M :
                       (reg_hit(rsD, writeregW) && regwriteW)                ? FWD_D_W : FWD_D_RF;
    assign forwardbD = (reg_hit(rtD, writeregM) && regwriteM && !memtoregM) ? FWD_D_M :
                       (reg_hit(rtD, writeregW) && regwriteW)                ? FWD_D_W : FWD_D_RF;
    assign forwardaE = (reg_hit(rsE, writeregM) && regwriteM) ? FWD_E_M :
                       (reg_hit(rsE, writeregW) && regwriteW) ? FWD_E_W : FWD_E_RF;
    assign forwardbE = (reg_hit(rtE, writeregM) && regwriteM) ? FWD_E_M :
                       (reg_hit(rtE, writeregW) && regwriteW) ? FWD_E_W : FWD_E_RF;

    assign lwstall   = memtoregE && (reg_hit(writeregE, rsD) || reg_hit(writeregE, rtD));
    assign br_hit_rs = (regwriteE && reg_hit(writeregE, rsD)) || (memtoregM && reg_hit(writeregM, rsD));
    assign br_hit_rt = (regwriteE && reg_hit(writeregE, rtD)) || (memtoregM && reg_hit(writeregM, rtD));
    assign brstall   = (branchD && (br_hit_rs || br_hit_rt)) || (jrD && br_hit_rs);
    assign d_stall   = divstall || lwstall || brstall;

    // An exception seen during a D-memory wait is deferred until the access ends.
    assign flush_now = !data_busyM && (exceptM || pend_q);
    assign pend_d    = flush_now ? 1'b0 : ((exceptM && data_busyM) ? 1'b1 : pend_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end

    hazard_div_timer #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_timer (
        .clk        (clk),
        .resetn     (resetn),
        .divE       (divE),
        .hold       (data_busyM),
        .cancel     (flush_now),
        .divstall   (divstall),
        .div_start  (tmr_start),
        .div_cancel (tmr_cancel)
    );

    assign div_start  = resetn && tmr_start;
    assign div_cancel = resetn && tmr_cancel;
    assign stallW     = 1'b0;

    // Priority: flush > memstall > divstall > lw/br stall > fetch stall.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushF = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (resetn) begin
            if (flush_now) begin
                flushF = 1'b1;
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
            end else if (data_busyM) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else begin
                if (divstall) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                end else if (lwstall || brstall) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
                if (inst_busyF) begin
                    stallF = 1'b1;
                    flushD = !d_stall;
                end
                if (!d_stall) begin
                    flushE = jumpD || (branchD && !balD);
                end
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the control rules.
module tb_hazard_ctrl_mc;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic branchD, jrD, jumpD, balD, regwriteE, memtoregE, divE;
    logic regwriteM, memtoregM, regwriteW, inst_busyF, data_busyM, exceptM;
    logic [1:0] forwardaD, forwardbD, forwardaE, forwardbE;
    logic div_start, div_cancel;
    logic stallF, stallD, stallE, stallM, stallW;
    logic flushF, flushD, flushE, flushM, flushW;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: cycles elapsed since the divide started (-1 = no divide),
    // and whether an exception is waiting for the memory access to finish.
    int m_div  = -1;
    bit m_pend = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl_mc #(
        .REG_AW     (5),
        .DIV_CYCLES (DC),
        .CNT_W      (3)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rsD        (rsD),
        .rtD        (rtD),
        .branchD    (branchD),
        .jrD        (jrD),
        .jumpD      (jumpD),
        .balD       (balD),
        .rsE        (rsE),
        .rtE        (rtE),
        .writeregE  (writeregE),
        .regwriteE  (regwriteE),
        .memtoregE  (memtoregE),
        .divE       (divE),
        .writeregM  (writeregM),
        .regwriteM  (regwriteM),
        .memtoregM  (memtoregM),
        .writeregW  (writeregW),
        .regwriteW  (regwriteW),
        .inst_busyF (inst_busyF),
        .data_busyM (data_busyM),
        .exceptM    (exceptM),
        .forwardaD  (forwardaD),
        .forwardbD  (forwardbD),
        .forwardaE  (forwardaE),
        .forwardbE  (forwardbE),
        .div_start  (div_start),
        .div_cancel (div_cancel),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .stallM     (stallM),
        .stallW     (stallW),
        .flushF     (flushF),
        .flushD     (flushD),
        .flushE     (flushE),
        .flushM     (flushM),
        .flushW     (flushW)
    );

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic bit dep(input logic [4:0] r);
        return (regwriteE && hit(writeregE, r)) || (memtoregM && hit(writeregM, r));
    endfunction

    function automatic logic [1:0] fd(input logic [4:0] r);
        if (regwriteM && !memtoregM && hit(writeregM, r)) return 2'b01;
        if (regwriteW && hit(writeregW, r)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] fe(input logic [4:0] r);
        if (regwriteM && hit(writeregM, r)) return 2'b10;
        if (regwriteW && hit(writeregW, r)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {branchD, jrD, jumpD, balD, regwriteE, memtoregE, divE} = '0;
        {regwriteM, memtoregM, regwriteW, inst_busyF, data_busyM, exceptM} = '0;
    endtask

    // One clock: check outputs mid-cycle against the model, advance the model, cross the edge.
    task automatic cyc(input string tag);
        bit busy, done, idle, fl, mem, dst, lw, br, dsome, start, cancel;
        logic [4:0] es, ef;
        logic [1:0] ed;
        #3;
        busy  = (m_div >= 1) && (m_div <= DC);
        done  = (m_div == DC + 1);
        idle  = !busy && !done;
        fl    = !data_busyM && (exceptM || m_pend);
        mem   = data_busyM;
        dst   = divE && !done;
        lw    = memtoregE && (hit(writeregE, rsD) || hit(writeregE, rtD));
        br    = (branchD && (dep(rsD) || dep(rtD))) || (jrD && dep(rsD));
        dsome = dst || lw || br;
        start = idle && divE && !mem && !fl;
        cancel = busy && fl;
        es = '0;
        ef = '0;
        ed = '0;
        if (resetn) begin
            ed = {start, cancel};
            if (fl) begin
                ef = 5'b11110;
            end else if (mem) begin
                es = 5'b11110;
                ef = 5'b00001;
            end else begin
                if (dst) es = 5'b11100;
                else if (lw || br) begin
                    es = 5'b11000;
                    ef[2] = 1'b1;
                end
                if (inst_busyF) begin
                    es[4] = 1'b1;
                    if (!dsome) ef[3] = 1'b1;
                end
                if (!dsome) ef[2] = jumpD || (branchD && !balD);
            end
        end
        chk({tag, ":stall"}, {3'b000, stallF, stallD, stallE, stallM, stallW}, {3'b000, es});
        chk({tag, ":flush"}, {3'b000, flushF, flushD, flushE, flushM, flushW}, {3'b000, ef});
        chk({tag, ":div"}, {6'd0, div_start, div_cancel}, {6'd0, ed});
        chk({tag, ":fwd"}, {forwardaD, forwardbD, forwardaE, forwardbE},
            {fd(rsD), fd(rtD), fe(rsE), fe(rtE)});
        if (!resetn) begin
            m_div  = -1;
            m_pend = 1'b0;
        end else begin
            if (fl) m_pend = 1'b0;
            else if (exceptM && data_busyM) m_pend = 1'b1;
            if (fl) m_div = -1;
            else if (start) m_div = 1;
            else if (done) m_div = -1;
            else if (busy) m_div++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_in();
        resetn = 1'b0;
        cyc("reset");
        divE = 1'b1;
        data_busyM = 1'b1;
        exceptM = 1'b1;
        inst_busyF = 1'b1;
        cyc("reset_busy_inputs");
        clr_in();
        resetn = 1'b1;
        cyc("idle");

        // load-use, then the load reaches W and feeds E
        rsD = 5'd2; rtD = 5'd5; writeregE = 5'd2; regwriteE = 1'b1; memtoregE = 1'b1;
        cyc("lwstall");
        clr_in();
        rsE = 5'd2; writeregW = 5'd2; regwriteW = 1'b1;
        cyc("lw_fwdW");

        // branch on a value produced by the add in E, then forwarded from M
        clr_in();
        branchD = 1'b1; rsD = 5'd3; rtD = 5'd0; writeregE = 5'd3; regwriteE = 1'b1;
        cyc("brstall");
        clr_in();
        branchD = 1'b1; rsD = 5'd3; writeregM = 5'd3; regwriteM = 1'b1;
        cyc("br_fwdM");

        // jr only looks at rs
        clr_in();
        jrD = 1'b1; jumpD = 1'b1; rsD = 5'd5; rtD = 5'd4; writeregE = 5'd4; regwriteE = 1'b1;
        cyc("jr_rt_ignored");

        // register 0 never matches
        clr_in();
        lwstall_zero: begin
            rsD = 5'd0; writeregE = 5'd0; memtoregE = 1'b1; regwriteE = 1'b1;
            rsE = 5'd0; writeregM = 5'd0; regwriteM = 1'b1;
            cyc("reg0");
        end

        // divide: 5 stalled cycles, advances on the 6th
        clr_in();
        divE = 1'b1;
        for (int i = 0; i < 6; i++) cyc("div_run");
        divE = 1'b0;
        cyc("div_after");

        // exception while the divider is busy with cnt=2
        divE = 1'b1;
        cyc("div_start2");
        cyc("div_cnt3");
        exceptM = 1'b1;
        cyc("div_cancel");
        exceptM = 1'b0;
        cyc("div_restart");
        divE = 1'b0;
        for (int i = 0; i < 6; i++) cyc("div_drain");

        // exception held behind a 3-cycle D-memory wait
        clr_in();
        exceptM = 1'b1;
        data_busyM = 1'b1;
        for (int i = 0; i < 3; i++) cyc("pend_wait");
        exceptM = 1'b0;
        data_busyM = 1'b0;
        cyc("pend_fire");
        cyc("pend_clear");

        // fetch stall alone, and behind a load-use stall
        inst_busyF = 1'b1;
        jumpD = 1'b1;
        cyc("fetch");
        rsD = 5'd7; writeregE = 5'd7; memtoregE = 1'b1;
        cyc("fetch_lw");
        clr_in();

        // reset during BUSY, then a full restart
        divE = 1'b1;
        cyc("rst_div0");
        cyc("rst_div1");
        resetn = 1'b0;
        cyc("rst_in_busy");
        resetn = 1'b1;
        for (int i = 0; i < 7; i++) cyc("rst_div_full");
        clr_in();
        cyc("rst_done");

        // random traffic over a small register set so dependencies are common
        for (int i = 0; i < 500; i++) begin
            rsD       = 5'($urandom_range(0, 3));
            rtD       = 5'($urandom_range(0, 3));
            rsE       = 5'($urandom_range(0, 3));
            rtE       = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3));
            regwriteE = 1'($urandom_range(0, 1));
            memtoregE = ($urandom_range(0, 3) == 0);
            regwriteM = 1'($urandom_range(0, 1));
            memtoregM = ($urandom_range(0, 3) == 0);
            regwriteW = 1'($urandom_range(0, 1));
            branchD   = ($urandom_range(0, 3) == 0);
            jrD       = !branchD && ($urandom_range(0, 5) == 0);
            jumpD     = ($urandom_range(0, 5) == 0);
            balD      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) divE = !divE;
            inst_busyF = ($urandom_range(0, 3) == 0);
            data_busyM = ($urandom_range(0, 5) == 0);
            exceptM    = ($urandom_range(0, 19) == 0);
            resetn     = ($urandom_range(0, 149) != 0);
            cyc("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
